// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone slave backed by a register-array memory: in-order acks at a
// fixed latency, aux tag passthrough, stall backpressure and bus-abort support.
module wb_mem_responder #(
    parameter int ADDR_BITS       = 8,
    parameter int DATA_BITS       = 8,
    parameter int SEL_BITS        = DATA_BITS / 8,
    parameter int AUX_WIDTH       = 16,
    parameter int ACK_LATENCY     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_EVERY     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [ADDR_BITS-1:0] i_wb_addr,
    input  logic [DATA_BITS-1:0] i_wb_data,
    input  logic [SEL_BITS-1:0]  i_wb_sel,
    input  logic [AUX_WIDTH-1:0] i_aux,
    output logic                 o_wb_stall,
    output logic                 o_wb_ack,
    output logic [DATA_BITS-1:0] o_wb_data,
    output logic [AUX_WIDTH-1:0] o_aux,
    output logic [4:0]           o_outstanding
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int HEAD  = ACK_LATENCY - 1;
    localparam int INJ_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [INJ_W-1:0] INJ_LAST = INJ_W'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);
    localparam logic [4:0] MAX_CNT = 5'(MAX_OUTSTANDING);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic                 rst_d_q;
    logic [4:0]           count_q, count_d;
    logic [INJ_W-1:0]     inj_cnt_q, inj_cnt_d;
    logic [ACK_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_BITS-1:0] data_q [ACK_LATENCY];
    logic [DATA_BITS-1:0] data_d [ACK_LATENCY];
    logic [AUX_WIDTH-1:0] aux_q  [ACK_LATENCY];
    logic [AUX_WIDTH-1:0] aux_d  [ACK_LATENCY];

    logic                 inject;
    logic                 accept;
    logic                 ack;
    logic                 wr_en;
    logic [DATA_BITS-1:0] rd_word;
    logic [DATA_BITS-1:0] wr_word;

    // Stall depends only on registered state (plus reset), never on the request lines.
    assign o_wb_stall = i_rst || rst_d_q || ((count_q == MAX_CNT) && !vld_q[HEAD]) || inject;
    assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign ack        = vld_q[HEAD] && i_wb_cyc && !i_rst;
    assign wr_en      = accept && i_wb_we;
    assign rd_word    = mem_q[i_wb_addr];

    always_comb begin
        inject    = 1'b0;
        inj_cnt_d = inj_cnt_q;
        if (STALL_EVERY > 0) begin
            inject    = (inj_cnt_q == INJ_LAST);
            inj_cnt_d = inject ? '0 : inj_cnt_q + 1'b1;
        end
    end

    always_comb begin
        wr_word = rd_word;
        for (int k = 0; k < SEL_BITS; k++) begin
            if (i_wb_sel[k]) begin
                wr_word[k*8 +: 8] = i_wb_data[k*8 +: 8];
            end
        end
    end

    // Writes complete at acceptance, so their ack slot carries zero data.
    always_comb begin
        vld_d     = '0;
        data_d    = '{default: '0};
        aux_d     = '{default: '0};
        vld_d[0]  = accept;
        data_d[0] = i_wb_we ? '0 : rd_word;
        aux_d[0]  = i_aux;
        for (int i = 1; i < ACK_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
            aux_d[i]  = aux_q[i-1];
        end
        if (!i_wb_cyc) begin
            vld_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (!i_wb_cyc) begin
            count_d = '0;
        end else if (accept && !ack) begin
            count_d = count_q + 5'd1;
        end else if (!accept && ack) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        rst_d_q <= i_rst;
        if (i_rst) begin
            vld_q     <= '0;
            count_q   <= '0;
            inj_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            count_q   <= count_d;
            inj_cnt_q <= inj_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < ACK_LATENCY; i++) begin
            data_q[i] <= data_d[i];
            aux_q[i]  <= aux_d[i];
        end
        if (wr_en) begin
            mem_q[i_wb_addr] <= wr_word;
        end
    end

    assign o_wb_ack      = ack;
    assign o_wb_data     = ack ? data_q[HEAD] : '0;
    assign o_aux         = ack ? aux_q[HEAD] : '0;
    assign o_outstanding = count_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: three instances cover the default build,
// a 16-bit/2-outstanding build and a stall-injection build.
module tb_wb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stb;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  sel;
    logic [15:0] aux;
    logic        cyc_a, cyc_b, cyc_c;

    logic        stall_a, ack_a, stall_b, ack_b, stall_c, ack_c;
    logic [7:0]  data_a, data_c;
    logic [15:0] data_b;
    logic [15:0] aux_a, aux_b, aux_c;
    logic [4:0]  out_a, out_b, out_c;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    typedef struct {
        int          t;
        logic [15:0] d;
        logic [15:0] x;
    } ev_t;

    ev_t ack_a_q[$];
    ev_t ack_b_q[$];
    ev_t ack_c_q[$];
    int  acc_a_q[$];
    int  acc_b_q[$];
    int  acc_c_q[$];
    int  max_out_b = 0;
    int  both_b    = 0;

    wb_mem_responder dut_a (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_a), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata[7:0]), .i_wb_sel(sel[0:0]), .i_aux(aux),
        .o_wb_stall(stall_a), .o_wb_ack(ack_a), .o_wb_data(data_a), .o_aux(aux_a),
        .o_outstanding(out_a)
    );

    wb_mem_responder #(.DATA_BITS(16), .MAX_OUTSTANDING(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_b), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .i_aux(aux),
        .o_wb_stall(stall_b), .o_wb_ack(ack_b), .o_wb_data(data_b), .o_aux(aux_b),
        .o_outstanding(out_b)
    );

    wb_mem_responder #(.STALL_EVERY(3)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_c), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata[7:0]), .i_wb_sel(sel[0:0]), .i_aux(aux),
        .o_wb_stall(stall_c), .o_wb_ack(ack_c), .o_wb_data(data_c), .o_aux(aux_c),
        .o_outstanding(out_c)
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (ack_a) ack_a_q.push_back(ev_t'{t: cyc_n, d: {8'h00, data_a}, x: aux_a});
        if (ack_b) ack_b_q.push_back(ev_t'{t: cyc_n, d: data_b, x: aux_b});
        if (ack_c) ack_c_q.push_back(ev_t'{t: cyc_n, d: {8'h00, data_c}, x: aux_c});
        if (cyc_a && stb && !stall_a) acc_a_q.push_back(cyc_n);
        if (cyc_b && stb && !stall_b) acc_b_q.push_back(cyc_n);
        if (cyc_c && stb && !stall_c) acc_c_q.push_back(cyc_n);
        if (int'(out_b) > max_out_b) max_out_b = int'(out_b);
        if (ack_b && cyc_b && stb && !stall_b) both_b++;
        if (out_c > 5'd4) $display("FAIL out_c_limit: got %0d, need <= 4", out_c);
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, need finish before 100000 ns");
        $fatal(1);
    end

    function automatic logic stall_of(input int which);
        case (which)
            0:       return stall_a;
            1:       return stall_b;
            default: return stall_c;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        ack_a_q.delete(); ack_b_q.delete(); ack_c_q.delete();
        acc_a_q.delete(); acc_b_q.delete(); acc_c_q.delete();
        max_out_b = 0;
        both_b    = 0;
    endtask

    // Holds the request on the bus until the selected instance accepts it.
    task automatic send(input int which, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input logic [1:0] s, input logic [15:0] x);
        int  waited = 0;
        bit  done   = 0;
        stb = 1'b1; we = w; addr = a; wdata = d; sel = s; aux = x;
        while (!done) begin
            @(negedge clk);
            if (!stall_of(which)) done = 1;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 40) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: dut %0d addr %h not accepted, need accept within 40 cycles", which, a);
                done = 1;
            end
        end
        stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0; aux = '0;
        cyc_a = 1'b0; cyc_b = 1'b0; cyc_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL rst_stall: got %b need 1", stall_a); end
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b need 0", ack_a); end
        n_checks++; if (out_a !== 5'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d need 0", out_a); end
        n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h need 00", data_a); end
        n_checks++; if (aux_a !== 16'h0000) begin n_fail++; $display("FAIL rst_aux: got %h need 0000", aux_a); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL rst_stall_after: got %b need 1", stall_a); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL rst_stall_release_a: got %b need 0", stall_a); end
        n_checks++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL rst_stall_release_b: got %b need 0", stall_b); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int t0;
        cyc_a = 1'b1;
        clear_mon();
        t0 = cyc_n;
        send(0, 1'b1, 8'h61, 16'h0061, 2'b01, 16'h0001);
        send(0, 1'b0, 8'h61, 16'h0000, 2'b00, 16'h0000);
        idle(8);
        n_checks++; if (acc_a_q.size() != 2) begin n_fail++; $display("FAIL wr_rd_accepts: got %0d need 2", acc_a_q.size()); end
        n_checks++;
        if (ack_a_q.size() != 2) begin
            n_fail++; $display("FAIL wr_rd_acks: got %0d need 2", ack_a_q.size());
        end else begin
            n_checks++; if (ack_a_q[0].t != t0 + 4) begin n_fail++; $display("FAIL wr_ack_time: got %0d need %0d", ack_a_q[0].t, t0 + 4); end
            n_checks++; if (ack_a_q[0].d !== 16'h0000) begin n_fail++; $display("FAIL wr_ack_data: got %h need 0000", ack_a_q[0].d); end
            n_checks++; if (ack_a_q[0].x !== 16'h0001) begin n_fail++; $display("FAIL wr_ack_aux: got %h need 0001", ack_a_q[0].x); end
            n_checks++; if (ack_a_q[1].t != t0 + 5) begin n_fail++; $display("FAIL rd_ack_time: got %0d need %0d", ack_a_q[1].t, t0 + 5); end
            n_checks++; if (ack_a_q[1].d !== 16'h0061) begin n_fail++; $display("FAIL rd_ack_data: got %h need 0061", ack_a_q[1].d); end
            n_checks++; if (ack_a_q[1].x !== 16'h0000) begin n_fail++; $display("FAIL rd_ack_aux: got %h need 0000", ack_a_q[1].x); end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int off [6] = '{0, 1, 4, 5, 8, 9};
        cyc_b = 1'b1;
        for (int i = 0; i < 6; i++) send(1, 1'b1, 8'(i), 16'h1111 * 16'(i + 1), 2'b11, 16'h0000);
        idle(8);
        clear_mon();
        t0 = cyc_n;
        for (int i = 0; i < 6; i++) send(1, 1'b0, 8'(i), 16'h0000, 2'b00, 16'h0100 + 16'(i));
        idle(10);
        n_checks++;
        if (acc_b_q.size() != 6) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d need 6", acc_b_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (acc_b_q[i] != t0 + off[i]) begin n_fail++; $display("FAIL b2b_accept_time[%0d]: got %0d need %0d", i, acc_b_q[i], t0 + off[i]); end
            end
        end
        n_checks++;
        if (ack_b_q.size() != 6) begin
            n_fail++; $display("FAIL b2b_acks: got %0d need 6", ack_b_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (ack_b_q[i].t != t0 + off[i] + 4) begin n_fail++; $display("FAIL b2b_ack_time[%0d]: got %0d need %0d", i, ack_b_q[i].t, t0 + off[i] + 4); end
                n_checks++;
                if (ack_b_q[i].d !== 16'h1111 * 16'(i + 1)) begin n_fail++; $display("FAIL b2b_ack_data[%0d]: got %h need %h", i, ack_b_q[i].d, 16'h1111 * 16'(i + 1)); end
                n_checks++;
                if (ack_b_q[i].x !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL b2b_ack_aux[%0d]: got %h need %h", i, ack_b_q[i].x, 16'h0100 + 16'(i)); end
            end
        end
        n_checks++; if (max_out_b != 2) begin n_fail++; $display("FAIL b2b_max_outstanding: got %0d need 2", max_out_b); end
        n_checks++; if (both_b != 4) begin n_fail++; $display("FAIL b2b_accept_with_ack: got %0d need 4", both_b); end
    endtask

    task automatic test_byte_enables();
        clear_mon();
        send(1, 1'b1, 8'h10, 16'hAAAA, 2'b11, 16'h0001);
        send(1, 1'b1, 8'h10, 16'h5555, 2'b01, 16'h0002);
        send(1, 1'b0, 8'h10, 16'h0000, 2'b00, 16'h0003);
        idle(10);
        n_checks++;
        if (ack_b_q.size() != 3) begin
            n_fail++; $display("FAIL be_acks: got %0d need 3", ack_b_q.size());
        end else begin
            n_checks++; if (ack_b_q[0].d !== 16'h0000) begin n_fail++; $display("FAIL be_write_ack_data: got %h need 0000", ack_b_q[0].d); end
            n_checks++; if (ack_b_q[2].d !== 16'hAA55) begin n_fail++; $display("FAIL be_read_data: got %h need AA55", ack_b_q[2].d); end
            n_checks++; if (ack_b_q[2].x !== 16'h0003) begin n_fail++; $display("FAIL be_read_aux: got %h need 0003", ack_b_q[2].x); end
        end
        cyc_b = 1'b0;
    endtask

    task automatic test_abort();
        int t1;
        clear_mon();
        send(0, 1'b0, 8'h01, 16'h0000, 2'b00, 16'h0010);
        send(0, 1'b0, 8'h02, 16'h0000, 2'b00, 16'h0011);
        send(0, 1'b0, 8'h03, 16'h0000, 2'b00, 16'h0012);
        idle(1);
        cyc_a = 1'b0;
        @(negedge clk);
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL abort_ack_forced: got %b need 0", ack_a); end
        n_checks++; if (out_a !== 5'd3) begin n_fail++; $display("FAIL abort_outstanding_before: got %0d need 3", out_a); end
        @(posedge clk);
        #1;
        cyc_a = 1'b1;
        @(negedge clk);
        n_checks++; if (out_a !== 5'd0) begin n_fail++; $display("FAIL abort_outstanding_after: got %0d need 0", out_a); end
        idle(8);
        n_checks++; if (ack_a_q.size() != 0) begin n_fail++; $display("FAIL abort_no_acks: got %0d need 0", ack_a_q.size()); end
        t1 = cyc_n;
        send(0, 1'b0, 8'h61, 16'h0000, 2'b00, 16'h0077);
        idle(6);
        n_checks++;
        if (ack_a_q.size() != 1) begin
            n_fail++; $display("FAIL abort_resume_acks: got %0d need 1", ack_a_q.size());
        end else begin
            n_checks++; if (ack_a_q[0].t != t1 + 4) begin n_fail++; $display("FAIL abort_resume_time: got %0d need %0d", ack_a_q[0].t, t1 + 4); end
            n_checks++; if (ack_a_q[0].d !== 16'h0061) begin n_fail++; $display("FAIL abort_resume_data: got %h need 0061", ack_a_q[0].d); end
            n_checks++; if (ack_a_q[0].x !== 16'h0077) begin n_fail++; $display("FAIL abort_resume_aux: got %h need 0077", ack_a_q[0].x); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send(0, 1'b1, 8'h30, 16'h003C, 2'b01, 16'h0005);
        send(0, 1'b1, 8'h31, 16'h00C3, 2'b01, 16'h0006);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL midrst_stall_in_reset: got %b need 1", stall_a); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL midrst_stall_after: got %b need 1", stall_a); end
        n_checks++; if (out_a !== 5'd0) begin n_fail++; $display("FAIL midrst_outstanding: got %0d need 0", out_a); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL midrst_stall_release: got %b need 0", stall_a); end
        @(posedge clk);
        #1;
        idle(6);
        n_checks++; if (ack_a_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_acks: got %0d need 0", ack_a_q.size()); end
        clear_mon();
        send(0, 1'b0, 8'h30, 16'h0000, 2'b00, 16'h0007);
        send(0, 1'b0, 8'h31, 16'h0000, 2'b00, 16'h0008);
        idle(8);
        n_checks++;
        if (ack_a_q.size() != 2) begin
            n_fail++; $display("FAIL midrst_read_acks: got %0d need 2", ack_a_q.size());
        end else begin
            n_checks++; if (ack_a_q[0].d !== 16'h003C) begin n_fail++; $display("FAIL midrst_read0: got %h need 003C", ack_a_q[0].d); end
            n_checks++; if (ack_a_q[1].d !== 16'h00C3) begin n_fail++; $display("FAIL midrst_read1: got %h need 00C3", ack_a_q[1].d); end
        end
        cyc_a = 1'b0;
    endtask

    task automatic test_stall_inject();
        int nxt = 0;
        int stalls[$];
        cyc_c = 1'b1;
        clear_mon();
        stb = 1'b1; we = 1'b1; wdata = 16'h005A; sel = 2'b01;
        for (int c = 0; c < 12; c++) begin
            aux  = 16'(nxt);
            addr = 8'h40 + 8'(nxt);
            @(negedge clk);
            if (stall_c) stalls.push_back(c);
            else nxt++;
            @(posedge clk);
            #1;
        end
        stb = 1'b0;
        idle(8);
        n_checks++; if (nxt != 8) begin n_fail++; $display("FAIL inj_accepts: got %0d need 8", nxt); end
        n_checks++;
        if (stalls.size() != 4) begin
            n_fail++; $display("FAIL inj_stall_count: got %0d need 4", stalls.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (stalls[i+1] - stalls[i] != 3) begin n_fail++; $display("FAIL inj_stall_period[%0d]: got %0d need 3", i, stalls[i+1] - stalls[i]); end
            end
        end
        n_checks++;
        if (ack_c_q.size() != 8 || acc_c_q.size() != 8) begin
            n_fail++; $display("FAIL inj_acks: got %0d acks %0d accepts need 8", ack_c_q.size(), acc_c_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (ack_c_q[i].x !== 16'(i)) begin n_fail++; $display("FAIL inj_ack_aux[%0d]: got %h need %h", i, ack_c_q[i].x, 16'(i)); end
                n_checks++;
                if (ack_c_q[i].t != acc_c_q[i] + 4) begin n_fail++; $display("FAIL inj_ack_time[%0d]: got %0d need %0d", i, ack_c_q[i].t, acc_c_q[i] + 4); end
            end
        end
        cyc_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byte_enables();
        test_abort();
        test_reset_mid();
        test_stall_inject();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
